// File: rtl/serial_add_sub_if.sv
// serial_add_sub_if: start/done request and result bundle for serial_add_sub
interface serial_add_sub_if #(parameter int WIDTH = 8) ();
  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  modport master (output start, sub, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, sub, a, b, cin, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/serial_add_sub.sv
// serial_add_sub: multi-cycle add/subtract, DIGIT bits per clock, LSB first
module serial_add_sub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic             clk,
  input logic             rst_n,
  serial_add_sub_if.slave bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N) + 1;
  if (WIDTH < 2 || DIGIT < 1 || WIDTH % DIGIT != 0) begin : g_bad_params
    $error("serial_add_sub: DIGIT must divide WIDTH and WIDTH must be >= 2");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t                 state, state_nx;
  logic [WIDTH-1:0]       ar, br, sr, sr_nx;
  logic [WIDTH+DIGIT-1:0] cat;
  logic [CW-1:0]          cnt;
  logic                   cr;
  logic [DIGIT:0]         c;
  logic [DIGIT-1:0]       s;
  logic                   accept, last;
  assign accept   = bus.start && (state == IDLE || state == DONE);
  assign last     = cnt == CW'(N - 1);
  assign bus.busy = state == RUN;
  assign bus.done = state == DONE;
  assign cat      = {s, sr};
  assign sr_nx    = cat[WIDTH+DIGIT-1:DIGIT];
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // an accept wins from IDLE or DONE; RUN ignores start until its last digit
  always_comb begin
    state_nx = accept ? RUN : (state == RUN) ? (last ? DONE : RUN) : IDLE;
  end
  // DIGIT-cell ripple fed by the low operand bits and the carry register
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cr;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]   = ar[i] ^ br[i] ^ c[i];
      c[i+1] = (ar[i] & br[i]) | (c[i] & (ar[i] ^ br[i]));
    end
  end
  // operand load on accept, then shift one digit per RUN cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ar  <= '0;
      br  <= '0;
      sr  <= '0;
      cr  <= 1'b0;
      cnt <= '0;
    end else if (accept) begin
      ar  <= bus.a;
      br  <= bus.sub ? ~bus.b : bus.b;
      sr  <= '0;
      cr  <= bus.cin ^ bus.sub;
      cnt <= '0;
    end else if (state == RUN) begin
      ar  <= ar >> DIGIT;
      br  <= br >> DIGIT;
      sr  <= sr_nx;
      cr  <= c[DIGIT];
      cnt <= cnt + CW'(1);
    end
  // results change only on the edge that enters DONE
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.sum  <= '0;
      bus.cout <= 1'b0;
      bus.ovf  <= 1'b0;
    end else if (state == RUN && last) begin
      bus.sum  <= sr_nx;
      bus.cout <= c[DIGIT];
      bus.ovf  <= c[DIGIT] ^ c[DIGIT-1];
    end
endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: random and directed checks of serial_add_sub in three shapes
module tb_serial_add_sub;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;
  serial_add_sub_if #(.WIDTH(8))  if0 ();
  serial_add_sub_if #(.WIDTH(16)) if1 ();
  serial_add_sub_if #(.WIDTH(8))  if2 ();
  serial_add_sub #(.WIDTH(8),  .DIGIT(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  serial_add_sub #(.WIDTH(16), .DIGIT(4)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  serial_add_sub #(.WIDTH(8),  .DIGIT(8)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  // {busy, done, cout, ovf, sum zero-extended to 16}
  function automatic logic [19:0] obs(input int cfg);
    if (cfg == 0) return {if0.busy, if0.done, if0.cout, if0.ovf, 8'h00, if0.sum};
    if (cfg == 1) return {if1.busy, if1.done, if1.cout, if1.ovf, if1.sum};
    return {if2.busy, if2.done, if2.cout, if2.ovf, 8'h00, if2.sum};
  endfunction

  // reference: plain integer arithmetic; returns {cout, ovf, sum16}
  function automatic logic [17:0] model(input int w, input logic sb, input logic [15:0] av,
                                        input logic [15:0] bv, input logic ci);
    int m   = 1 << w;
    int h   = m >> 1;
    int ua  = int'(av) % m;
    int ub  = int'(bv) % m;
    int sa  = ua >= h ? ua - m : ua;
    int sbb = ub >= h ? ub - m : ub;
    int c   = int'(ci);
    int ur  = sb ? ua - ub - c : ua + ub + c;
    int sr  = sb ? sa - sbb - c : sa + sbb + c;
    logic co = sb ? (ur >= 0) : (ur >= m);
    logic ov = (sr < -h) || (sr >= h);
    int us  = (ur + m) % m;
    return {co, ov, 16'(us)};
  endfunction

  task automatic drive(input int cfg, input logic st, input logic sb, input logic [15:0] av,
                       input logic [15:0] bv, input logic ci);
    if (cfg == 0) begin
      if0.start = st; if0.sub = sb; if0.a = av[7:0]; if0.b = bv[7:0]; if0.cin = ci;
    end else if (cfg == 1) begin
      if1.start = st; if1.sub = sb; if1.a = av; if1.b = bv; if1.cin = ci;
    end else begin
      if2.start = st; if2.sub = sb; if2.a = av[7:0]; if2.b = bv[7:0]; if2.cin = ci;
    end
  endtask

  // one operation; lat = negedges after the start edge until done, -1 on timeout
  task automatic run_op(input int cfg, input logic sb, input logic [15:0] av, input logic [15:0] bv,
                        input logic ci, output int lat, output int bc, output logic [17:0] r);
    @(negedge clk);
    drive(cfg, 1'b1, sb, av, bv, ci);
    @(posedge clk);
    #1 drive(cfg, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    lat = -1;
    bc  = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (obs(cfg)[18]) begin lat = cyc; break; end
      if (obs(cfg)[19]) bc++;
    end
    r = obs(cfg)[17:0];
  endtask

  task automatic test_reset;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs(k) !== 20'h0) begin
        errors++;
        $display("FAIL reset cfg%0d: got %h want 00000", k, obs(k));
      end
    end
  endtask

  task automatic test_directed;
    logic       ts[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] ta[6] = '{8'hFF, 8'h7F, 8'h80, 8'h05, 8'h80, 8'h10};
    logic [7:0] tb[6] = '{8'h01, 8'h01, 8'h80, 8'h07, 8'h01, 8'h00};
    logic       tc[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [9:0] te[6] = '{{2'b10, 8'h00}, {2'b01, 8'h80}, {2'b11, 8'h01},
                          {2'b00, 8'hFE}, {2'b11, 8'h7F}, {2'b10, 8'h0F}};
    int lat, bc;
    logic [17:0] r;
    for (int i = 0; i < 6; i++) begin
      run_op(0, ts[i], {8'h0, ta[i]}, {8'h0, tb[i]}, tc[i], lat, bc, r);
      checks++;
      if ({r[17:16], r[7:0]} !== te[i]) begin
        errors++;
        $display("FAIL directed%0d result: got cout/ovf/sum %h want %h", i, {r[17:16], r[7:0]}, te[i]);
      end
      checks++;
      if (lat !== 9 || bc !== 8) begin
        errors++;
        $display("FAIL directed%0d latency: got done %0d busy %0d want 9 8", i, lat, bc);
      end
    end
  endtask

  task automatic test_start_rules;
    logic [17:0] ea = model(8, 1'b0, 16'h3C, 16'h21, 1'b0);
    logic [17:0] eb = model(8, 1'b1, 16'h90, 16'h23, 1'b0);
    logic [17:0] ec = model(8, 1'b0, 16'h7E, 16'h05, 1'b1);
    int lat;
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 16'h3C, 16'h21, 1'b0);
    @(posedge clk);
    #1 drive(0, 1'b0, 1'b0, 16'h3C, 16'h21, 1'b0);
    lat = -1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (if0.done) begin lat = cyc; break; end
      drive(0, cyc == 1, 1'b1, 16'hAA, 16'h55, 1'b1);
    end
    checks++;
    if (lat !== 9 || obs(0)[17:0] !== ea) begin
      errors++;
      $display("FAIL ignored_start: got lat %0d res %h want 9 %h", lat, obs(0)[17:0], ea);
    end
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 16'h90, 16'h23, 1'b0);
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 16'h7E, 16'h05, 1'b1);
    lat = -1;
    for (int cyc = 2; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (if0.done) begin lat = cyc; break; end
    end
    checks++;
    if (lat !== 9 || obs(0)[17:0] !== eb) begin
      errors++;
      $display("FAIL back_to_back first: got lat %0d res %h want 9 %h", lat, obs(0)[17:0], eb);
    end
    @(negedge clk);
    checks++;
    if (obs(0)[19:18] !== 2'b10) begin
      errors++;
      $display("FAIL back_to_back gap: got busy/done %b want 10", obs(0)[19:18]);
    end
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    lat = -1;
    for (int cyc = 2; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (if0.done) begin lat = cyc; break; end
    end
    checks++;
    if (lat !== 9 || obs(0)[17:0] !== ec) begin
      errors++;
      $display("FAIL back_to_back second: got lat %0d res %h want 9 %h", lat, obs(0)[17:0], ec);
    end
  endtask

  task automatic test_reset_mid;
    int lat, bc, seen;
    logic [17:0] r;
    logic [15:0] av, bv;
    run_op(0, 1'b0, 16'h12, 16'h34, 1'b0, lat, bc, r);
    checks++;
    if (r !== model(8, 1'b0, 16'h12, 16'h34, 1'b0)) begin
      errors++;
      $display("FAIL pre_reset op: got %h want %h", r, model(8, 1'b0, 16'h12, 16'h34, 1'b0));
    end
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 16'h0F, 16'h0F, 1'b0);
    @(posedge clk);
    #1 drive(0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (obs(0) !== 20'h0) begin
      errors++;
      $display("FAIL mid_reset outputs: got %h want 00000", obs(0));
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (if0.done) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL mid_reset done_pulse: got %0d pulses want 0", seen);
    end
    av = 16'($urandom);
    bv = 16'($urandom);
    run_op(0, 1'b1, av, bv, 1'b1, lat, bc, r);
    checks++;
    if (r !== model(8, 1'b1, av, bv, 1'b1) || lat !== 9) begin
      errors++;
      $display("FAIL post_reset op: got %h lat %0d want %h lat 9", r, lat, model(8, 1'b1, av, bv, 1'b1));
    end
  endtask

  task automatic test_random(input int cfg, input int w, input int n, input int ops);
    int lat, bc;
    logic [17:0] r, e;
    logic [15:0] av, bv;
    logic sb, ci;
    for (int i = 0; i < ops; i++) begin
      av = 16'($urandom);
      bv = 16'($urandom);
      sb = 1'($urandom);
      ci = 1'($urandom);
      e  = model(w, sb, av, bv, ci);
      run_op(cfg, sb, av, bv, ci, lat, bc, r);
      checks++;
      if (r !== e) begin
        errors++;
        $display("FAIL random cfg%0d op%0d: a %h b %h sub %b cin %b got %h want %h", cfg, i, av, bv, sb, ci, r, e);
      end
      checks++;
      if (lat !== n + 1 || bc !== n) begin
        errors++;
        $display("FAIL random cfg%0d op%0d latency: got done %0d busy %0d want %0d %0d", cfg, i, lat, bc, n + 1, n);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) drive(k, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    test_reset;
    test_directed;
    test_start_rules;
    test_reset_mid;
    test_random(0, 8, 8, 100);
    test_random(1, 16, 4, 1000);
    test_random(2, 8, 1, 200);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
